// File: rtl/llc_pwm_gen_pkg.sv
// llc_pwm_gen_pkg: shared types, default timing constants and clamp helper for the LLC PWM block
package llc_pwm_gen_pkg;
    localparam int CNT_W = 12;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t ONE         = cnt_t'(1);
    localparam cnt_t CNT_MIN_DEF = cnt_t'(416);
    localparam cnt_t CNT_MAX_DEF = cnt_t'(625);
    localparam cnt_t DEAD_DEF    = cnt_t'(25);
    localparam cnt_t SS_STEP     = cnt_t'(1);
    typedef enum logic [2:0] {IDLE, DEAD_A, HIGH_A, DEAD_B, HIGH_B} state_e;
    function automatic cnt_t clamp(input cnt_t x, input cnt_t lo, input cnt_t hi);
        return x < lo ? lo : (x > hi ? hi : x);
    endfunction
endpackage

// File: rtl/llc_pwm_gen_if.sv
// llc_pwm_gen_if: run request / period command in, gate drive and status pulses out
interface llc_pwm_gen_if;
    import llc_pwm_gen_pkg::*;
    logic en;
    cnt_t cnt_period;
    logic pwm_a;
    logic pwm_b;
    logic adc_trig;
    logic period_start;
    logic active;
    modport master (output en, cnt_period, input pwm_a, pwm_b, adc_trig, period_start, active);
    modport slave  (input en, cnt_period, output pwm_a, pwm_b, adc_trig, period_start, active);
endinterface

// File: rtl/llc_pwm_gen_filter.sv
// llc_pwm_gen_filter: two-flop capture of the slow period command; shadow takes the clamped value once stable
module llc_pwm_gen_filter
    import llc_pwm_gen_pkg::*;
#(
    parameter cnt_t CNT_MIN = CNT_MIN_DEF,
    parameter cnt_t CNT_MAX = CNT_MAX_DEF
) (
    input  logic clk,
    input  logic rstp,
    input  cnt_t cnt_i,
    output cnt_t shadow_o
);
    cnt_t s1_q, s2_q, shadow_q;
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            s1_q     <= '0;
            s2_q     <= '0;
            shadow_q <= CNT_MIN;
        end else begin
            s1_q <= cnt_i;
            s2_q <= s1_q;
            if (s1_q == s2_q) shadow_q <= clamp(s2_q, CNT_MIN, CNT_MAX);
        end
    end
    assign shadow_o = shadow_q;
endmodule

// File: rtl/llc_pwm_gen.sv
// llc_pwm_gen: complementary 50% LLC half-bridge drive with fixed deadtime and mid-HIGH_A ADC trigger.
// Define SOFT_START_EN to ramp the period up from CNT_MIN after each start.
module llc_pwm_gen
    import llc_pwm_gen_pkg::*;
#(
    parameter cnt_t CNT_MIN = CNT_MIN_DEF,
    parameter cnt_t CNT_MAX = CNT_MAX_DEF,
    parameter cnt_t DEAD    = DEAD_DEF
) (
    input  logic clk,
    input  logic rstp,
    llc_pwm_gen_if.slave bus
);
    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d, p_q, p_d, half_a_q, half_a_d, half_b_q, half_b_d;
    cnt_t   shadow, len, p_next;
    logic   last, load, adc_d;
    logic   pwm_a_q, pwm_b_q, adc_trig_q, period_start_q, active_q;

    llc_pwm_gen_filter #(.CNT_MIN(CNT_MIN), .CNT_MAX(CNT_MAX)) u_filter (
        .clk      (clk),
        .rstp     (rstp),
        .cnt_i    (bus.cnt_period),
        .shadow_o (shadow)
    );

    always_comb begin
        len  = state_q == HIGH_A ? half_a_q - DEAD : state_q == HIGH_B ? half_b_q - DEAD : DEAD;
        last = cnt_q == len - ONE;
        case (state_q)
            IDLE:    state_d = bus.en ? DEAD_A : IDLE;
            DEAD_A:  state_d = last ? HIGH_A : DEAD_A;
            HIGH_A:  state_d = last ? DEAD_B : HIGH_A;
            DEAD_B:  state_d = last ? HIGH_B : DEAD_B;
            HIGH_B:  state_d = last ? (bus.en ? DEAD_A : IDLE) : HIGH_B;
            default: state_d = IDLE;
        endcase
        load  = state_d == DEAD_A && state_q != DEAD_A;
        cnt_d = state_d != state_q || state_q == IDLE ? '0 : cnt_q + ONE;
`ifdef SOFT_START_EN
        p_next = state_q == IDLE ? CNT_MIN : (p_q + SS_STEP < shadow ? p_q + SS_STEP : shadow);
`else
        p_next = shadow;
`endif
        // the period and its halves only change at a period boundary
        p_d      = load ? p_next : p_q;
        half_a_d = load ? p_next >> 1 : half_a_q;
        half_b_d = load ? p_next - (p_next >> 1) : half_b_q;
        adc_d    = state_d == HIGH_A && cnt_d == (half_a_q - DEAD) >> 1;
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            p_q            <= CNT_MIN;
            half_a_q       <= CNT_MIN >> 1;
            half_b_q       <= CNT_MIN - (CNT_MIN >> 1);
            pwm_a_q        <= 1'b0;
            pwm_b_q        <= 1'b0;
            adc_trig_q     <= 1'b0;
            period_start_q <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            p_q            <= p_d;
            half_a_q       <= half_a_d;
            half_b_q       <= half_b_d;
            pwm_a_q        <= state_d == HIGH_A;
            pwm_b_q        <= state_d == HIGH_B;
            adc_trig_q     <= adc_d;
            period_start_q <= load;
            active_q       <= state_d != IDLE;
        end
    end

    assign bus.pwm_a        = pwm_a_q;
    assign bus.pwm_b        = pwm_b_q;
    assign bus.adc_trig     = adc_trig_q;
    assign bus.period_start = period_start_q;
    assign bus.active       = active_q;
endmodule

// File: tb/tb_llc_pwm_gen.sv
// tb_llc_pwm_gen: directed periods, clamping, shadowing, en drop and async reset on llc_pwm_gen
module tb_llc_pwm_gen;
    logic clk, rstp;
    llc_pwm_gen_if bus ();

    llc_pwm_gen dut (.clk(clk), .rstp(rstp), .bus(bus));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int vec_n = 0, err_n = 0;
    int cyc = 0, ps_cyc = 0, ps_tot = 0, pe_n = 0, ovl_n = 0;
    int a_cnt = 0, b_cnt = 0, adc_n = 0, a_idx = 0, adc_off = 0, gap = 0, min_gap = 9999;
    int last_len = 0, last_a = 0, last_b = 0, last_adc_n = 0, last_adc_off = 0;
    bit in_per = 0, prev_act = 0, prev_a = 0, prev_b = 0;

    task automatic chk(input string tag, input int got, input int exp);
        vec_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs();
        return {27'd0, bus.pwm_a, bus.pwm_b, bus.adc_trig, bus.period_start, bus.active};
    endfunction

    // per-period statistics gathered away from the active edge
    always @(negedge clk) begin
        if (rstp) begin
            in_per = 0; prev_act = 0; prev_a = 0; prev_b = 0; gap = 0;
        end else begin
            cyc++;
            if (bus.pwm_a && bus.pwm_b) ovl_n++;
            if (in_per && (bus.period_start || (prev_act && !bus.active))) begin
                last_len = cyc - ps_cyc; last_a = a_cnt; last_b = b_cnt;
                last_adc_n = adc_n; last_adc_off = adc_off; pe_n++;
            end
            if (!bus.active) in_per = 0;
            if (bus.period_start) begin
                in_per = 1; ps_cyc = cyc; a_cnt = 0; b_cnt = 0; adc_n = 0; ps_tot++;
            end
            a_idx = bus.pwm_a ? (prev_a ? a_idx + 1 : 0) : 0;
            if (bus.adc_trig) adc_off = a_idx;
            if ((bus.pwm_a && !prev_a) || (bus.pwm_b && !prev_b)) begin
                if (gap < min_gap) min_gap = gap;
                gap = 0;
            end else if (!bus.pwm_a && !bus.pwm_b && bus.active) gap++;
            a_cnt += int'(bus.pwm_a);
            b_cnt += int'(bus.pwm_b);
            adc_n += int'(bus.adc_trig);
            prev_a = bus.pwm_a; prev_b = bus.pwm_b; prev_act = bus.active;
        end
    end

    task automatic wait_pe(input int n);
        int tgt, k;
        tgt = pe_n + n;
        k = 0;
        while (pe_n < tgt && k < 3000 * n) begin
            @(posedge clk);
            k++;
        end
        if (pe_n < tgt) chk("pe_timeout", pe_n, tgt);
    endtask

    task automatic wait_gate(input string tag, input bit b);
        int k;
        k = 0;
        while ((b ? bus.pwm_b : bus.pwm_a) !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) chk(tag, 0, 1);
    endtask

    task automatic chk_period(input string tag, input int len, input int a, input int b, input int adc);
        chk({tag, "_len"}, last_len, len);
        chk({tag, "_a"}, last_a, a);
        chk({tag, "_b"}, last_b, b);
        chk({tag, "_adc_off"}, last_adc_off, adc);
        chk({tag, "_adc_n"}, last_adc_n, 1);
    endtask

    initial begin
        int pst, pe0, e1, e2;
        rstp = 1'b1; bus.en = 1'b0; bus.cnt_period = 12'd520;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", outs(), 0);
        @(posedge clk); #1 rstp = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_outs", outs(), 0);
        chk("idle_ps", ps_tot, 0);

        @(posedge clk); #1 bus.en = 1'b1;
        wait_pe(2);
        chk_period("p520", 520, 235, 235, 117);

        #1 bus.cnt_period = 12'd300;
        wait_pe(1);
        chk("keep520_len", last_len, 520);
        wait_pe(1);
        chk_period("p416", 416, 183, 183, 91);
        #1 bus.cnt_period = 12'd900;
        wait_pe(2);
        chk_period("p625", 625, 287, 288, 143);
        #1 bus.cnt_period = 12'd521;
        wait_pe(2);
        chk_period("p521", 521, 235, 236, 117);

        #1 bus.cnt_period = 12'd520;
        wait_pe(2);
        wait_gate("wait_high_a", 1'b0);
        #1 bus.cnt_period = 12'd600;
        wait_pe(1);
        chk("midchg_len", last_len, 520);
        wait_pe(1);
        chk_period("p600", 600, 275, 275, 137);

        pe0 = pe_n;
        for (int i = 0; i < 1300; i++) begin
            @(posedge clk);
            #1 bus.cnt_period = i[0] ? 12'd700 : 12'd520;
        end
        chk("tog_len", last_len, 600);
        chk("tog_pe", int'(pe_n - pe0 >= 2), 1);

        #1 bus.cnt_period = 12'd520;
        wait_pe(2);
        #1 bus.en = 1'b0;
        wait_pe(1);
        chk_period("drop", 520, 235, 235, 117);
        pst = ps_tot;
        repeat (700) @(negedge clk);
        chk("drop_ps", ps_tot, pst);
        chk("drop_outs", outs(), 0);

        bus.en = 1'b1;
        wait_gate("wait_high_b", 1'b1);
        #1 rstp = 1'b1;
        #1 chk("rst_pwm_b", int'(bus.pwm_b), 0);
        chk("rst_active", int'(bus.active), 0);
        bus.en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstp = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.en = 1'b1;
`ifdef SOFT_START_EN
        e1 = 416; e2 = 417;
`else
        e1 = 520; e2 = 520;
`endif
        wait_pe(1);
        chk("start1_len", last_len, e1);
        wait_pe(1);
        chk("start2_len", last_len, e2);

        chk("overlap", ovl_n, 0);
        chk("min_gap", min_gap, 25);
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end
endmodule
